// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the FORTH core.
// Walks each instruction through fetch / latch / increment / execute, issues
// the PC mode code and memory strobes, drives the data bus during PC loads
// and keeps a small hardware return-address stack for call/return.
module pc_sequencer #(
  parameter int RS_DEPTH = 8,
  parameter int RS_AW    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              halt,
  input  logic              exec_done,
  input  logic              jmp_req,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [31:0]       target,
  input  logic [31:0]       pc_value,
  output logic [2:0]        pc_mode,
  output logic              mem_rd,
  output logic              ir_load,
  output logic              bus_oe,
  output logic [31:0]       bus_out,
  output logic [RS_AW:0]    rs_level,
  output logic              fault,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_CLR   = 3'd0,
    S_IDLE  = 3'd1,
    S_FETCH = 3'd2,
    S_LATCH = 3'd3,
    S_INCR  = 3'd4,
    S_EXEC  = 3'd5,
    S_LOAD  = 3'd6,
    S_FAULT = 3'd7
  } state_e;

  localparam logic [2:0] MODE_CLEAR = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_DRIVE = 3'b010;
  localparam logic [2:0] MODE_IDLE  = 3'b011;
  localparam logic [2:0] MODE_INC   = 3'b100;

  localparam logic [RS_AW:0] RS_FULL = RS_DEPTH[RS_AW:0];

  state_e            state;
  state_e            state_n;
  logic [RS_AW:0]    level_n;
  logic              fault_n;
  logic              push;
  logic [31:0]       load_val;
  logic [RS_AW-1:0]  rs_ptr;
  logic [RS_AW-1:0]  pop_idx;
  logic [31:0]       stack [RS_DEPTH];

  assign rs_ptr    = rs_level[RS_AW-1:0];
  assign pop_idx   = rs_ptr - 1'b1;
  assign state_dbg = state;

  // PC mode code presented while sitting in a given state.
  function automatic logic [2:0] mode_of(input state_e s);
    case (s)
      S_CLR:   mode_of = MODE_CLEAR;
      S_FETCH: mode_of = MODE_DRIVE;
      S_INCR:  mode_of = MODE_INC;
      S_LOAD:  mode_of = MODE_LOAD;
      default: mode_of = MODE_IDLE;
    endcase
  endfunction

  // Next-state, stack-pointer and load-value decision for the coming edge.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_n  = state;
    level_n  = rs_level;
    fault_n  = fault;
    push     = 1'b0;
    load_val = '0;
    case (state)
      S_CLR:   state_n = S_IDLE;
      S_IDLE:  if (!halt) state_n = S_FETCH;
      S_FETCH: state_n = S_LATCH;
      S_LATCH: state_n = S_INCR;
      S_INCR:  state_n = S_EXEC;
      S_EXEC: begin
        if (exec_done) begin
          if (ret_req) begin
            if (rs_level == '0) begin
              fault_n = 1'b1;
              state_n = S_FAULT;
            end else begin
              load_val = stack[pop_idx];
              level_n  = rs_level - 1'b1;
              state_n  = S_LOAD;
            end
          end else if (call_req) begin
            if (rs_level == RS_FULL) begin
              fault_n = 1'b1;
              state_n = S_FAULT;
            end else begin
              push     = 1'b1;
              load_val = target;
              level_n  = rs_level + 1'b1;
              state_n  = S_LOAD;
            end
          end else if (jmp_req) begin
            load_val = target;
            state_n  = S_LOAD;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_LOAD:  state_n = S_IDLE;
      default: state_n = S_FAULT;
    endcase
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (reset) begin
      state    <= S_CLR;
      rs_level <= '0;
      fault    <= 1'b0;
      pc_mode  <= MODE_CLEAR;
      mem_rd   <= 1'b0;
      ir_load  <= 1'b0;
      bus_oe   <= 1'b0;
      bus_out  <= '0;
    end else begin
      state    <= state_n;
      rs_level <= level_n;
      fault    <= fault_n;
      pc_mode  <= mode_of(state_n);
      mem_rd   <= (state_n == S_FETCH);
      ir_load  <= (state_n == S_LATCH);
      bus_oe   <= (state_n == S_LOAD);
      bus_out  <= (state_n == S_LOAD) ? load_val : '0;
    end
  end

  // Return-stack storage: push writes the entry just above the current top.
  always_ff @(posedge clock) begin
    // NOTE: stack contents are not reset; rs_level alone defines which entries are valid.
    if (!reset && push) stack[rs_ptr] <= pc_value;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table-driven instruction stream plus
// hand-written overflow, underflow, priority, halt and reset-in-LOAD sequences.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        halt;
  logic        exec_done;
  logic        jmp_req;
  logic        call_req;
  logic        ret_req;
  logic [31:0] target;
  logic [31:0] pc_value;
  logic [2:0]  pc_mode;
  logic        mem_rd;
  logic        ir_load;
  logic        bus_oe;
  logic [31:0] bus_out;
  logic [3:0]  rs_level;
  logic        fault;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic started = 1'b0;

  pc_sequencer #(.RS_DEPTH(8), .RS_AW(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .halt      (halt),
    .exec_done (exec_done),
    .jmp_req   (jmp_req),
    .call_req  (call_req),
    .ret_req   (ret_req),
    .target    (target),
    .pc_value  (pc_value),
    .pc_mode   (pc_mode),
    .mem_rd    (mem_rd),
    .ir_load   (ir_load),
    .bus_oe    (bus_oe),
    .bus_out   (bus_out),
    .rs_level  (rs_level),
    .fault     (fault),
    .state_dbg (state_dbg)
  );

  always #5 clock = ~clock;

  // Environment model of the PC register obeying the mode code.
  logic [31:0] pc_reg = 32'hDEAD_BEEF;
  assign pc_value = pc_reg;
  always @(posedge clock) begin
    case (pc_mode)
      3'b000: pc_reg <= '0;
      3'b001: if (bus_oe) pc_reg <= bus_out;
      3'b100: pc_reg <= pc_reg + 32'd1;
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus must never be driven while the PC is driving it as an address.
  always @(negedge clock) begin
    if (started) check("no_bus_conflict", {31'd0, bus_oe && (pc_mode == 3'b010)}, 32'd0);
  end

  task automatic step(input logic h, input logic d, input logic j, input logic c,
                      input logic r, input logic [31:0] t);
    halt = h; exec_done = d; jmp_req = j; call_req = c; ret_req = r; target = t;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic run_to_exec();
    repeat (4) idle_step();
    check("run_to_exec_state", {29'd0, state_dbg}, 32'd5);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) idle_step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        halt, done, jmp, call, ret;
    logic [31:0] target;
    logic [2:0]  st, mode;
    logic        rd, ir, oe;
    logic [31:0] bus;
    logic [3:0]  level;
    logic        flt;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic h, d, j, c, r, input logic [31:0] t,
                     input logic [2:0] st, mode, input logic rd, ir, oe,
                     input logic [31:0] bus, input logic [3:0] lv, input logic flt,
                     input logic [31:0] pc);
    vec_t v;
    v.halt = h; v.done = d; v.jmp = j; v.call = c; v.ret = r; v.target = t;
    v.st = st; v.mode = mode; v.rd = rd; v.ir = ir; v.oe = oe; v.bus = bus;
    v.level = lv; v.flt = flt; v.pc = pc;
    vecs.push_back(v);
  endtask

  // IDLE -> FETCH -> LATCH -> INCR -> EXEC for an instruction at address p.
  task automatic add_fetch(input logic [31:0] p, input logic [3:0] lv);
    add(0, 0, 0, 0, 0, 0, 3'd2, 3'b010, 1, 0, 0, 0, lv, 0, p);
    add(0, 0, 0, 0, 0, 0, 3'd3, 3'b011, 0, 1, 0, 0, lv, 0, p);
    add(0, 0, 0, 0, 0, 0, 3'd4, 3'b100, 0, 0, 0, 0, lv, 0, p);
    add(0, 0, 0, 0, 0, 0, 3'd5, 3'b011, 0, 0, 0, 0, lv, 0, p + 32'd1);
  endtask

  task automatic add_exit_none(input logic [31:0] p, input logic [3:0] lv);
    add(0, 1, 0, 0, 0, 0, 3'd1, 3'b011, 0, 0, 0, 0, lv, 0, p);
  endtask

  // EXEC -> LOAD -> IDLE; the PC takes the bus value at the end of LOAD.
  task automatic add_branch(input logic j, c, r, input logic [31:0] t, input logic [31:0] bus,
                            input logic [3:0] lv, input logic [31:0] pc_before);
    add(0, 1, j, c, r, t, 3'd6, 3'b001, 0, 0, 1, bus, lv, 0, pc_before);
    add(0, 0, 0, 0, 0, 0, 3'd1, 3'b011, 0, 0, 0, 0, lv, 0, bus);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; halt = 0; exec_done = 0; jmp_req = 0; call_req = 0; ret_req = 0; target = 0;

    // Reset for two cycles; CLR outputs and an empty stack.
    do_reset(2);
    started = 1'b1;
    check("reset_state",   {29'd0, state_dbg}, 32'd0);
    check("reset_pc_mode", {29'd0, pc_mode},   32'd0);
    check("reset_mem_rd",  {31'd0, mem_rd},    32'd0);
    check("reset_ir_load", {31'd0, ir_load},   32'd0);
    check("reset_bus_oe",  {31'd0, bus_oe},    32'd0);
    check("reset_bus_out", bus_out,            32'd0);
    check("reset_level",   {28'd0, rs_level},  32'd0);
    check("reset_fault",   {31'd0, fault},     32'd0);
    check("reset_pc",      pc_value,           32'd0);

    // Instruction stream: straight-line, jump, call, return.
    add(0, 0, 0, 0, 0, 0, 3'd1, 3'b011, 0, 0, 0, 0, 4'd0, 0, 32'd0);
    for (int p = 0; p < 4; p++) begin
      add_fetch(p, 4'd0);
      if (p == 2) add(0, 0, 1, 0, 0, 32'h77, 3'd5, 3'b011, 0, 0, 0, 0, 4'd0, 0, 32'd3);
      add_exit_none(p + 1, 4'd0);
    end
    add_fetch(32'd4, 4'd0);
    add_branch(1, 0, 0, 32'h100, 32'h100, 4'd0, 32'd5);
    add_fetch(32'h100, 4'd0);
    add_branch(1, 0, 0, 32'd7, 32'd7, 4'd0, 32'h101);
    add_fetch(32'd7, 4'd0);
    add_branch(0, 1, 0, 32'h200, 32'h200, 4'd1, 32'd8);
    for (int p = 32'h200; p < 32'h203; p++) begin
      add_fetch(p, 4'd1);
      add_exit_none(p + 1, 4'd1);
    end
    add_fetch(32'h203, 4'd1);
    add_branch(0, 0, 1, 32'hBAD, 32'd8, 4'd0, 32'h204);
    add_fetch(32'd8, 4'd0);
    add_exit_none(32'd9, 4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].halt, vecs[i].done, vecs[i].jmp, vecs[i].call, vecs[i].ret, vecs[i].target);
      check($sformatf("v%0d_state", i),   {29'd0, state_dbg}, {29'd0, vecs[i].st});
      check($sformatf("v%0d_pc_mode", i), {29'd0, pc_mode},   {29'd0, vecs[i].mode});
      check($sformatf("v%0d_mem_rd", i),  {31'd0, mem_rd},    {31'd0, vecs[i].rd});
      check($sformatf("v%0d_ir_load", i), {31'd0, ir_load},   {31'd0, vecs[i].ir});
      check($sformatf("v%0d_bus_oe", i),  {31'd0, bus_oe},    {31'd0, vecs[i].oe});
      check($sformatf("v%0d_bus_out", i), bus_out,            vecs[i].bus);
      check($sformatf("v%0d_level", i),   {28'd0, rs_level},  {28'd0, vecs[i].level});
      check($sformatf("v%0d_fault", i),   {31'd0, fault},     {31'd0, vecs[i].flt});
      check($sformatf("v%0d_pc", i),      pc_value,           vecs[i].pc);
    end

    // Overflow: nine nested calls with an eight-entry stack.
    do_reset(2);
    idle_step();
    for (int i = 0; i < 9; i++) begin
      run_to_exec();
      step(0, 1, 0, 1, 0, 32'h300 + 32'(i) * 32'h10);
      if (i < 8) begin
        check($sformatf("ovf_call%0d_state", i), {29'd0, state_dbg}, 32'd6);
        check($sformatf("ovf_call%0d_level", i), {28'd0, rs_level},  32'(i + 1));
        idle_step();
      end else begin
        check("ovf_state",   {29'd0, state_dbg}, 32'd7);
        check("ovf_fault",   {31'd0, fault},     32'd1);
        check("ovf_level",   {28'd0, rs_level},  32'd8);
        check("ovf_bus_oe",  {31'd0, bus_oe},    32'd0);
        check("ovf_pc_mode", {29'd0, pc_mode},   32'd3);
      end
    end
    repeat (3) begin
      idle_step();
      check("fault_hold_state", {29'd0, state_dbg}, 32'd7);
      check("fault_hold_flag",  {31'd0, fault},     32'd1);
    end
    do_reset(1);
    check("ovf_reset_state", {29'd0, state_dbg}, 32'd0);
    check("ovf_reset_fault", {31'd0, fault},     32'd0);
    check("ovf_reset_level", {28'd0, rs_level},  32'd0);

    // Underflow: return with an empty stack.
    idle_step();
    run_to_exec();
    step(0, 1, 0, 0, 1, 32'd0);
    check("udf_state", {29'd0, state_dbg}, 32'd7);
    check("udf_fault", {31'd0, fault},     32'd1);
    check("udf_level", {28'd0, rs_level},  32'd0);
    check("udf_mem_rd", {31'd0, mem_rd},   32'd0);

    // Priority: call and return together with one entry stacked; pop wins.
    do_reset(2);
    idle_step();
    run_to_exec();
    step(0, 1, 0, 1, 0, 32'h40);
    check("pri_call_level", {28'd0, rs_level}, 32'd1);
    check("pri_call_bus",   bus_out,           32'h40);
    idle_step();
    check("pri_after_call_pc", pc_value, 32'h40);
    run_to_exec();
    step(0, 1, 0, 1, 1, 32'h999);
    check("pri_state", {29'd0, state_dbg}, 32'd6);
    check("pri_level", {28'd0, rs_level},  32'd0);
    check("pri_bus",   bus_out,            32'd1);
    idle_step();
    check("pri_ret_pc", pc_value, 32'd1);

    // Halt raised mid-instruction: instruction completes, then holds in IDLE.
    step(0, 0, 0, 0, 0, 32'd0);
    check("halt_fetch", {31'd0, mem_rd}, 32'd1);
    repeat (3) step(1, 0, 0, 0, 0, 32'd0);
    check("halt_exec_state", {29'd0, state_dbg}, 32'd5);
    step(1, 1, 0, 0, 0, 32'd0);
    check("halt_idle_state", {29'd0, state_dbg}, 32'd1);
    repeat (3) begin
      step(1, 0, 0, 0, 0, 32'd0);
      check("halt_hold_state",  {29'd0, state_dbg}, 32'd1);
      check("halt_hold_mem_rd", {31'd0, mem_rd},    32'd0);
    end
    step(0, 0, 0, 0, 0, 32'd0);
    check("halt_release_state", {29'd0, state_dbg}, 32'd2);
    check("halt_release_pc",    pc_value,           32'd2);

    // Reset asserted while in LOAD.
    repeat (3) idle_step();
    step(0, 1, 1, 0, 0, 32'h500);
    check("rl_load_oe",  {31'd0, bus_oe}, 32'd1);
    check("rl_load_bus", bus_out,         32'h500);
    reset = 1'b1;
    idle_step();
    reset = 1'b0;
    check("rl_state",   {29'd0, state_dbg}, 32'd0);
    check("rl_bus_oe",  {31'd0, bus_oe},    32'd0);
    check("rl_bus_out", bus_out,            32'd0);
    check("rl_pc_mode", {29'd0, pc_mode},   32'd0);
    idle_step();
    check("rl_idle", {29'd0, state_dbg}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
